// File: rtl/constantin_write_agent.sv
// Runtime write/read-back agent for the constantin tunables.
// Two-half staging, atomic commit, one request outstanding.
module constantin_write_agent #(
  parameter int NUM_CONST = 26,
  parameter int IDX_W     = 5
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [IDX_W-1:0]        req_idx,
  input  logic [31:0]             req_data,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_err,
  output logic [63:0]             resp_data,
  output logic [NUM_CONST*64-1:0] const_value,
  output logic [NUM_CONST-1:0]    const_update,
  output logic [NUM_CONST-1:0]    const_override
);

  localparam logic [1:0] OP_WR_LO  = 2'd0;
  localparam logic [1:0] OP_WR_HI  = 2'd1;
  localparam logic [1:0] OP_COMMIT = 2'd2;
  localparam logic [1:0] OP_READ   = 2'd3;

  typedef enum logic {IDLE, RESP} state_t;

  state_t state;
  state_t state_nx;

  logic [63:0]      cv [NUM_CONST];
  logic [31:0]      stg_lo;
  logic [31:0]      stg_hi;
  logic [IDX_W-1:0] stg_idx;
  logic             stg_lo_ok;
  logic             stg_hi_ok;
  logic             err_q;
  logic [63:0]      data_q;

  logic             accept;
  logic             idx_ok;
  logic             hit;
  logic             err_c;
  logic             do_lo;
  logic             do_hi;
  logic             do_commit;
  logic             do_clr;
  logic [63:0]      rd_c;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = err_q;
  assign resp_data  = data_q;
  assign accept     = req_valid & req_ready;
  assign idx_ok     = {1'b0, req_idx} < (IDX_W+1)'(NUM_CONST);
  assign hit        = (stg_idx == req_idx);

  // Handshake FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state: accept moves to RESP, taken response returns to IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req_valid)  state_nx = RESP;
      RESP: if (resp_ready) state_nx = IDLE;
      default:              state_nx = IDLE;
    endcase
  end

  // Request decode: error and staging/commit actions
  always_comb begin
    err_c     = 1'b0;
    do_lo     = 1'b0;
    do_hi     = 1'b0;
    do_commit = 1'b0;
    do_clr    = 1'b0;
    rd_c      = '0;
    if (!idx_ok) begin
      err_c = 1'b1;
    end else begin
      unique case (req_op)
        OP_WR_LO: do_lo = 1'b1;
        OP_WR_HI: begin
          if (stg_lo_ok && hit) begin
            do_hi = 1'b1;
          end else begin
            err_c  = 1'b1;
            do_clr = 1'b1;
          end
        end
        OP_COMMIT: begin
          if (stg_lo_ok && stg_hi_ok && hit) begin
            do_commit = 1'b1;
          end else begin
            err_c  = 1'b1;
            do_clr = 1'b1;
          end
        end
        OP_READ: rd_c = cv[req_idx];
        default: err_c = 1'b1;
      endcase
    end
  end

  // Staging registers for the two halves
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stg_lo    <= '0;
      stg_hi    <= '0;
      stg_idx   <= '0;
      stg_lo_ok <= 1'b0;
      stg_hi_ok <= 1'b0;
    end else if (accept) begin
      if (do_lo) begin
        stg_lo    <= req_data;
        stg_idx   <= req_idx;
        stg_lo_ok <= 1'b1;
        stg_hi_ok <= 1'b0;
      end
      if (do_hi) begin
        stg_hi    <= req_data;
        stg_hi_ok <= 1'b1;
      end
      if (do_clr || do_commit) begin
        stg_lo_ok <= 1'b0;
        stg_hi_ok <= 1'b0;
      end
    end
  end

  // Committed bank, override flags and one-cycle update pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CONST; i++) cv[i] <= '0;
      const_update   <= '0;
      const_override <= '0;
    end else begin
      const_update <= '0;
      if (accept && do_commit) begin
        cv[req_idx]             <= {stg_hi, stg_lo};
        const_override[req_idx] <= 1'b1;
        const_update[req_idx]   <= 1'b1;
      end
    end
  end

  // Response registers, captured at accept and held until taken
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_q  <= 1'b0;
      data_q <= '0;
    end else if (accept) begin
      err_q  <= err_c;
      data_q <= rd_c;
    end
  end

  // Flatten the bank onto the consumer bus
  always_comb begin
    const_value = '0;
    for (int i = 0; i < NUM_CONST; i++) const_value[64*i +: 64] = cv[i];
  end

endmodule
